fpdiv: RTL and testbench
========================

FPDIV -- requirements
Module: fpdiv

Interface
REQ-001 SHALL have parameter: EXP_W, 5, exponent width (half precision).
REQ-002 SHALL have parameter: MAN_W, 10, stored fraction width; only the defaults are required to be supported.
REQ-003 SHALL have port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request pulse; sampled only when busy=0.
REQ-006 SHALL have port: a  input  16  dividend, IEEE-754 half.
REQ-007 SHALL have port: b  input  16  divisor, IEEE-754 half.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port: out  output  16  quotient a/b, held until the next accepted start.
REQ-011 SHALL have port: overflow  output  1  result saturated to infinity.
REQ-012 SHALL have port: sub  output  1  result underflowed and was flushed to zero.
REQ-013 SHALL have port: dz  output  1  divide by zero.

Function
REQ-014 SHALL implement FSM IDLE->DIVIDE->NORM->DONE->IDLE, with a,b latched on the edge where start=1 and the state is IDLE.
REQ-015 SHALL ignore start while busy=1, and SHALL keep the latched operands unchanged in that case.
REQ-016 SHALL produce sign = a[15]^b[15] in every result, including special results.
REQ-017 SHALL form significands ma={1,a[9:0]} and mb={1,b[9:0]}.
REQ-018 SHALL restoring-divide in DIVIDE, one quotient bit per cycle, for exactly MAN_W+2=12 cycles, giving q=floor(ma*2^11/mb).
REQ-019 SHALL normalise in NORM: if q[11]=1, frac=q[10:1] and e=ea-eb+15; otherwise frac=q[9:0] and e=ea-eb+14.
REQ-020 SHALL compute e in signed 7-bit arithmetic and SHALL round by truncation only.
REQ-021 SHALL, when e>=31, set out={sign,7C00 magnitude} and overflow=1.
REQ-022 SHALL, when e<=0, set out={sign,15'h0} and sub=1.
REQ-023 SHALL treat subnormal inputs (exp=0) as zero.
REQ-024 SHALL handle a=0 with b!=0 as out=signed zero with all flags 0.
REQ-025 SHALL handle b=0 with a!=0 as out=signed infinity, dz=1 and overflow=1.
REQ-026 SHALL handle a=0 with b=0 as out=16'h7E00 with dz=1.
REQ-027 SHALL treat any input with exp=31 as producing signed infinity with overflow=1.
REQ-028 SHALL resolve special cases at latch time but SHALL keep the same 14-cycle latency as normal operands.
REQ-029 SHALL assert busy from the edge after start until done is asserted.
REQ-030 SHALL place done 14 rising edges after the accepted start edge, high for exactly one cycle, with out and flags valid in that same cycle.
REQ-031 SHALL hold out and flags stable from done until the next accepted start, and SHALL clear the flags on that accept.
REQ-032 SHALL accept a start asserted in the DONE cycle (back-to-back operation).

Reset
REQ-033 SHALL, on RST=1 and regardless of CLK, set state=IDLE and busy=0, done=0, out=16'h0000, overflow=0, sub=0, dz=0.
REQ-034 SHALL abandon any operation in progress when RST is asserted mid-operation, with no done pulse issued.

Structure
REQ-035 SHALL place in shared package fp16_pkg: BIAS=15, EXP_MAX=31, INF_MAG=15'h7C00, QNAN=16'h7E00, and the state encoding.
REQ-036 SHALL isolate one restoring step (remainder in, divisor in, remainder out, quotient bit out) as sub-module fpdiv_step.

Verification
REQ-037 SHALL cover: a=4000 (2.0), b=3C00 (1.0) -> out=4000, all flags 0, done 14 edges after start.
REQ-038 SHALL cover: a=3C00, b=4000 -> out=3800; a=C200, b=4000 -> out=BE00.
REQ-039 SHALL cover: a=7800, b=0400 -> out=7C00, overflow=1; a=0400, b=7800 -> out=0000, sub=1.
REQ-040 SHALL cover: a=3C00, b=0000 -> out=7C00, dz=1, overflow=1; a=0000, b=0000 -> out=7E00, dz=1.
REQ-041 SHALL cover: start pulsed again at cycle 5 of an operation -> ignored, original result returned.
REQ-042 SHALL cover: RST raised at cycle 6 -> busy=0, out=0000 immediately; no done pulse; next start completes normally.

Source files
------------

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared half-precision constants, FSM encoding and special-case classifier
// Purpose : constants and helpers shared by the fpdiv block.
// Contents: BIAS, EXP_MAX, INF_MAG, QNAN, FSM state encoding, spec_t, classify().
package fp16_pkg;

  localparam int          BIAS    = 15;
  localparam int          EXP_MAX = 31;
  localparam logic [14:0] INF_MAG = 15'h7C00;
  localparam logic [15:0] QNAN    = 16'h7E00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_NORM   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Result of special-operand screening, decided when the operands are latched.
  typedef struct packed {
    logic        valid;
    logic [15:0] val;
    logic        ovf;
    logic        dz;
  } spec_t;

  // Subnormals count as zero; any exp=31 operand wins over the zero cases.
  function automatic spec_t classify(input logic [15:0] a, input logic [15:0] b);
    spec_t r;
    logic  s;
    logic  az;
    logic  bz;
    logic  ai;
    logic  bi;
    s  = a[15] ^ b[15];
    az = (a[14:10] == 5'd0);
    bz = (b[14:10] == 5'd0);
    ai = (a[14:10] == 5'(EXP_MAX));
    bi = (b[14:10] == 5'(EXP_MAX));
    r  = '0;
    if (ai || bi) begin
      r.valid = 1'b1;
      r.val   = {s, INF_MAG};
      r.ovf   = 1'b1;
    end else if (az && bz) begin
      r.valid = 1'b1;
      r.val   = {s, QNAN[14:0]};
      r.dz    = 1'b1;
    end else if (bz) begin
      r.valid = 1'b1;
      r.val   = {s, INF_MAG};
      r.ovf   = 1'b1;
      r.dz    = 1'b1;
    end else if (az) begin
      r.valid = 1'b1;
      r.val   = {s, 15'h0000};
    end
    return r;
  endfunction

endpackage

// File: rtl/fpdiv_if.sv
// rtl/fpdiv_if.sv - request/result bundle for the fpdiv divider
// Purpose : groups the divider handshake and data signals.
// Signals : start, a, b (requester -> divider); busy, done, out, overflow, sub, dz (divider -> requester).
// Modports: master = requester, slave = divider.
interface fpdiv_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        overflow;
  logic        sub;
  logic        dz;

  modport master (output start, a, b, input busy, done, out, overflow, sub, dz);
  modport slave  (input start, a, b, output busy, done, out, overflow, sub, dz);
endinterface

// File: rtl/fpdiv_step.sv
// rtl/fpdiv_step.sv - one restoring-division step
// Purpose : compares the partial remainder with the divisor, subtracts when it fits,
//           and returns the doubled remainder for the next step plus the quotient bit.
// Ports   : i_rem (partial remainder, < 2*divisor), i_div (divisor),
//           o_rem (next partial remainder, already shifted), o_bit (quotient bit).
module fpdiv_step #(
  parameter int W = 11
) (
  input  logic [W:0]   i_rem,
  input  logic [W-1:0] i_div,
  output logic [W:0]   o_rem,
  output logic         o_bit
);

  logic [W:0] w_diff;

  assign w_diff = i_rem - {1'b0, i_div};
  assign o_bit  = (i_rem >= {1'b0, i_div});
  // Either branch leaves a value below the divisor, so its top bit is free for the shift.
  assign o_rem  = o_bit ? {w_diff[W-1:0], 1'b0} : {i_rem[W-1:0], 1'b0};

endmodule

// File: rtl/fpdiv.sv
// rtl/fpdiv.sv - multi-cycle IEEE-754 half-precision divider
// Purpose : out = a / b, truncating, 14 edges from accepted start to done.
// Ports   : CLK  - clock, rising edge
//           RST  - asynchronous active-high reset
//           bus  - fpdiv_if.slave: start/a/b in, busy/done/out/overflow/sub/dz out
module fpdiv
  import fp16_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic   CLK,
  input logic   RST,
  fpdiv_if.slave bus
);

  localparam int QW = MAN_W + 2;

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [MAN_W+1:0] r_rem;
  logic [MAN_W:0]   r_div;
  logic [QW-1:0]    r_q;
  logic             r_sign;
  logic [EXP_W-1:0] r_ea;
  logic [EXP_W-1:0] r_eb;
  spec_t            r_spec;
  logic [15:0]      r_out;
  logic             r_ovf;
  logic             r_sub;
  logic             r_dz;
  logic             r_done;

  logic [MAN_W+1:0] w_rem_nxt;
  logic             w_bit;
  logic signed [6:0] w_e;
  logic [MAN_W-1:0] w_frac;

  fpdiv_step #(.W(MAN_W + 1)) u_step (
    .i_rem (r_rem),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_bit (w_bit)
  );

  // A set top quotient bit means a/b >= 1, so the bias is applied without the -1 correction.
  assign w_e = $signed({{(7-EXP_W){1'b0}}, r_ea}) - $signed({{(7-EXP_W){1'b0}}, r_eb})
             + (r_q[QW-1] ? 7'(BIAS) : 7'(BIAS - 1));
  assign w_frac = r_q[QW-1] ? r_q[QW-2:1] : r_q[QW-3:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_sign  <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_spec  <= '0;
      r_out   <= 16'h0000;
      r_ovf   <= 1'b0;
      r_sub   <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sign  <= bus.a[15] ^ bus.b[15];
            r_ea    <= bus.a[14:10];
            r_eb    <= bus.b[14:10];
            r_rem   <= {1'b0, 1'b1, bus.a[MAN_W-1:0]};
            r_div   <= {1'b1, bus.b[MAN_W-1:0]};
            r_q     <= '0;
            r_cnt   <= '0;
            r_spec  <= classify(bus.a, bus.b);
            r_ovf   <= 1'b0;
            r_sub   <= 1'b0;
            r_dz    <= 1'b0;
            r_state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          // Runs the full 12 steps even for special operands to keep latency fixed.
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[QW-2:0], w_bit};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(QW - 1)) begin
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_spec.valid) begin
            r_out <= r_spec.val;
            r_ovf <= r_spec.ovf;
            r_dz  <= r_spec.dz;
          end else if (w_e >= 7'(EXP_MAX)) begin
            r_out <= {r_sign, INF_MAG};
            r_ovf <= 1'b1;
          end else if (w_e <= 7'sd0) begin
            r_out <= {r_sign, 15'h0000};
            r_sub <= 1'b1;
          end else begin
            r_out <= {r_sign, w_e[EXP_W-1:0], w_frac};
          end
          r_state <= ST_DONE;
        end
        default: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.out      = r_out;
  assign bus.overflow = r_ovf;
  assign bus.sub      = r_sub;
  assign bus.dz       = r_dz;

endmodule

// File: tb/tb_fpdiv.sv
// tb/tb_fpdiv.sv - self-checking bench for fpdiv
module tb_fpdiv;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [2:0]  f;   // {overflow, sub, dz}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  vec_t vecs[18];

  always #5 clk = ~clk;

  fpdiv_if bus ();

  fpdiv dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [2:0] flags();
    return {bus.overflow, bus.sub, bus.dz};
  endfunction

  // Called mid-cycle; returns mid-cycle in the done cycle, so consecutive calls are back-to-back.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                       input logic [2:0] f, input string name);
    int n;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    chk({name, "_busy"}, 16'(bus.busy), 16'd1);
    chk({name, "_clr"}, 16'(flags()), 16'd0);
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_lat"}, 16'(n), 16'd14);
    chk({name, "_out"}, bus.out, q);
    chk({name, "_flg"}, 16'(flags()), 16'(f));
  endtask

  initial begin
    int n;
    int seen;
    vecs[0]  = '{16'h4000, 16'h3C00, 16'h4000, 3'b000};
    vecs[1]  = '{16'h3C00, 16'h4000, 16'h3800, 3'b000};
    vecs[2]  = '{16'hC200, 16'h4000, 16'hBE00, 3'b000};
    vecs[3]  = '{16'h7800, 16'h0400, 16'h7C00, 3'b100};
    vecs[4]  = '{16'h0400, 16'h7800, 16'h0000, 3'b010};
    vecs[5]  = '{16'h3C00, 16'h0000, 16'h7C00, 3'b101};
    vecs[6]  = '{16'h0000, 16'h0000, 16'h7E00, 3'b001};
    vecs[7]  = '{16'h0000, 16'h3C00, 16'h0000, 3'b000};
    vecs[8]  = '{16'h8000, 16'h3C00, 16'h8000, 3'b000};
    vecs[9]  = '{16'h3C00, 16'h3E00, 16'h3955, 3'b000};
    vecs[10] = '{16'h3C00, 16'hBC00, 16'hBC00, 3'b000};
    vecs[11] = '{16'h7C00, 16'h3C00, 16'h7C00, 3'b100};
    vecs[12] = '{16'h7800, 16'h3800, 16'h7C00, 3'b100};
    vecs[13] = '{16'h7A00, 16'h3C00, 16'h7A00, 3'b000};
    vecs[14] = '{16'h0400, 16'h3C00, 16'h0400, 3'b000};
    vecs[15] = '{16'h0400, 16'h4000, 16'h0000, 3'b010};
    vecs[16] = '{16'h0200, 16'h3C00, 16'h0000, 3'b000};
    vecs[17] = '{16'hBC00, 16'h0000, 16'hFC00, 3'b101};

    bus.start = 1'b0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    #12;
    chk("reset_out", bus.out, 16'h0000);
    chk("reset_ctl", 16'({bus.busy, bus.done, flags()}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, $sformatf("v%0d", i));
    end

    @(posedge clk);
    #1;
    chk("done_width", 16'(bus.done), 16'd0);
    chk("out_hold", bus.out, 16'hFC00);
    chk("flag_hold", 16'(flags()), 16'b101);

    // Second start at cycle 5 with different operands must be ignored.
    bus.start = 1'b1;
    bus.a     = 16'h3C00;
    bus.b     = 16'h4000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        bus.start = 1'b1;
        bus.a     = 16'h7800;
        bus.b     = 16'h0400;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("ign_lat", 16'(n), 16'd14);
    chk("ign_out", bus.out, 16'h3800);
    chk("ign_flg", 16'(flags()), 16'd0);
    @(posedge clk);
    #1;

    // Reset mid-operation at cycle 6.
    bus.start = 1'b1;
    bus.a     = 16'h4000;
    bus.b     = 16'h3C00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_out", bus.out, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    chk("rst_nodone", 16'(seen), 16'd0);
    do_op(16'h3C00, 16'h3E00, 16'h3955, 3'b000, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
